brq_ifu_id_skid: RTL

- IF→ID pipeline stage that sits directly downstream of the instruction prefetch buffer.
- Consumes its valid/ready instruction stream (rdata, addr, err, err_plus2) and presents one registered instruction per cycle to the decoder.
- A 2-entry skid buffer registers fetch_ready_o, so there is no combinational path from id_ready_i back into the prefetch buffer.
- Also tags compressed instructions, qualifies fetch errors, flushes on branch, and counts decode back-pressure cycles.

---
 rtl/brq_ifu_id_skid.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/brq_ifu_id_skid.sv
// IF->ID stage: 2-entry skid buffer between the prefetch buffer and the decoder.
// fetch_ready_o comes straight from the state register, so id_ready_i never reaches it combinationally.
module brq_ifu_id_skid #(
  parameter int StallCntW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fetch_valid_i,
  output logic                 fetch_ready_o,
  input  logic [31:0]          fetch_rdata_i,
  input  logic [31:0]          fetch_addr_i,
  input  logic                 fetch_err_i,
  input  logic                 fetch_err_plus2_i,
  output logic                 id_valid_o,
  input  logic                 id_ready_i,
  output logic [31:0]          id_instr_o,
  output logic [31:0]          id_pc_o,
  output logic                 id_is_compressed_o,
  output logic                 id_fetch_err_o,
  output logic                 id_fetch_err_plus2_o,
  output logic [StallCntW-1:0] stall_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_reg, state_next;

  logic        main_valid, skid_valid;
  logic        accept, pop;
  logic        load_main, load_skid, move_skid;

  logic [31:0] main_instr_reg, main_pc_reg;
  logic        main_comp_reg, main_err_reg, main_err_plus2_reg;
  logic [31:0] skid_instr_reg, skid_pc_reg;
  logic        skid_comp_reg, skid_err_reg, skid_err_plus2_reg;

  logic        in_comp, in_err_plus2;
  logic [31:0] in_instr;

  logic [StallCntW-1:0] stall_cnt_reg;

  assign main_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);

  assign fetch_ready_o = ~skid_valid;
  assign accept        = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop           = main_valid & id_ready_i;

  assign in_comp      = (fetch_rdata_i[1:0] != 2'b11);
  assign in_instr     = in_comp ? {16'h0000, fetch_rdata_i[15:0]} : fetch_rdata_i;
  assign in_err_plus2 = fetch_err_i & fetch_err_plus2_i & ~in_comp;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next = ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Payload registers carry no reset; validity lives entirely in state_reg.
  always_ff @(posedge clk_i) begin
    if (load_main) begin
      main_instr_reg     <= in_instr;
      main_pc_reg        <= fetch_addr_i;
      main_comp_reg      <= in_comp;
      main_err_reg       <= fetch_err_i;
      main_err_plus2_reg <= in_err_plus2;
    end else if (move_skid) begin
      main_instr_reg     <= skid_instr_reg;
      main_pc_reg        <= skid_pc_reg;
      main_comp_reg      <= skid_comp_reg;
      main_err_reg       <= skid_err_reg;
      main_err_plus2_reg <= skid_err_plus2_reg;
    end
    if (load_skid) begin
      skid_instr_reg     <= in_instr;
      skid_pc_reg        <= fetch_addr_i;
      skid_comp_reg      <= in_comp;
      skid_err_reg       <= fetch_err_i;
      skid_err_plus2_reg <= in_err_plus2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && !id_ready_i && !flush_i && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + StallCntW'(1);
    end
  end

  assign id_valid_o           = main_valid;
  assign busy_o               = main_valid;
  assign id_instr_o           = main_instr_reg;
  assign id_pc_o              = main_pc_reg;
  // Flags are qualified so they read 0 out of reset despite unreset payload.
  assign id_is_compressed_o   = main_valid & main_comp_reg;
  assign id_fetch_err_o       = main_valid & main_err_reg;
  assign id_fetch_err_plus2_o = main_valid & main_err_plus2_reg;
  assign stall_cnt_o          = stall_cnt_reg;

endmodule
